// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake ROM port between the download writer and the ROM reader.
// Define ROM_MAPPER_EN to build the 8-slot bank mapper on the read address path.
module rom_port_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [22:0]       rd_addr,
    output logic [DATA_W-1:0] rd_dout,
    output logic              rd_ack,
    input  logic              map_we,
    input  logic [2:0]        map_a,
    input  logic [5:0]        map_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_BUSY = 2'd1,
        S_RD_BUSY = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_wr_ack;
    logic              r_rd_ack;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [DATA_W-1:0] r_rd_dout;
    logic              r_last_wr;

    logic              w_wr_pend;
    logic              w_rd_pend;
    logic              w_mem_done;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_wr_done;
    logic              w_rd_done;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_pend  = wr_req ^ r_wr_ack;
    assign w_rd_pend  = rd_req ^ r_rd_ack;
    assign w_mem_done = (mem_ack == r_mem_req);

    // On a tie the side that was not served last wins.
    assign w_grant_wr = w_wr_pend && (!w_rd_pend || !r_last_wr);
    assign w_grant_rd = w_rd_pend && (!w_wr_pend ||  r_last_wr);

`ifdef ROM_MAPPER_EN
    logic [5:0] r_map [8];
    logic       r_use_map;
    logic [5:0] w_map_sel;

    // Slot 0 is hard-wired to bank 0, so writes to it are dropped.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) begin
                r_map[i] <= 6'(i);
            end
            r_use_map <= 1'b0;
        end else if (map_we && (map_a != 3'd0)) begin
            r_map[map_a] <= map_d;
            r_use_map    <= 1'b1;
        end
    end

    assign w_map_sel = r_map[rd_addr[21:19]];
    assign w_rd_addr = r_use_map ? ADDR_W'({w_map_sel, rd_addr[18:0]})
                                 : ADDR_W'(rd_addr);
`else
    logic w_unused_map;

    assign w_unused_map = ^{map_we, map_a, map_d};
    assign w_rd_addr    = ADDR_W'(rd_addr);
`endif

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = S_WR_BUSY;
                end else if (w_grant_rd) begin
                    w_state_nxt = S_RD_BUSY;
                end
            end
            S_WR_BUSY: if (w_mem_done) w_state_nxt = S_IDLE;
            S_RD_BUSY: if (w_mem_done) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_acc_wr  = 1'b0;
        w_acc_rd  = 1'b0;
        w_wr_done = 1'b0;
        w_rd_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_acc_wr = w_grant_wr;
                w_acc_rd = w_grant_rd;
            end
            S_WR_BUSY: w_wr_done = w_mem_done;
            S_RD_BUSY: w_rd_done = w_mem_done;
            default: ;
        endcase
    end

    // Request fields are frozen at accept so later mapper or input changes cannot disturb an outstanding access.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_rd_dout  <= '0;
            r_last_wr  <= 1'b0;
        end else begin
            if (w_acc_wr) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= wr_addr;
                r_mem_din  <= {wr_din[7:0], wr_din[15:8]};
                r_mem_req  <= ~r_mem_req;
            end else if (w_acc_rd) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_rd_addr;
                r_mem_req  <= ~r_mem_req;
            end
            if (w_wr_done) begin
                r_wr_ack  <= ~r_wr_ack;
                r_last_wr <= 1'b1;
            end
            if (w_rd_done) begin
                r_rd_dout <= mem_dout;
                r_rd_ack  <= ~r_rd_ack;
                r_last_wr <= 1'b0;
            end
        end
    end

    assign wr_ack   = r_wr_ack;
    assign rd_ack   = r_rd_ack;
    assign rd_dout  = r_rd_dout;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule
